branch_ctrl: RTL and testbench

Branch resolution and prediction controller for the pipelined core. It sits beside the EX-stage branch comparator and consumes its BrTaken result. It holds a bimodal predictor table of 2-bit saturating counters that the IF stage looks up, and it updates that table when each branch resolves. On a misprediction it issues a registered redirect and a multi-cycle flush sequence, and it keeps saturating branch and mispredict counters for performance readout.

---
 rtl/branch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution and bimodal prediction controller sitting beside the EX-stage comparator.
// Latency: prediction lookup is combinational; redirect/flush appear one cycle after the resolve edge.
// Backpressure: none; resolves arriving while a flush is in progress are squashed and ignored.
module branch_ctrl #(
  parameter int IDX_W        = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             br_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int          DEPTH      = 1 << IDX_W;
  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Predictor table of 2-bit saturating counters
  logic [1:0]       r_table [DEPTH];

  // Control state
  state_t           r_state;
  logic [2:0]       r_down;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;
  logic             r_flush;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  // Combinational helpers
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_ex_ctr;
  logic [1:0]       w_ex_ctr_nxt;
  logic             w_resolve;
  logic             w_actual;
  logic             w_mispredict;
  logic [31:0]      w_correct_pc;
  logic             w_unused;

  // Next-state values for the FSM and its registered outputs
  state_t           w_state_nxt;
  logic [2:0]       w_down_nxt;
  logic             w_redirect_valid_nxt;
  logic [31:0]      w_redirect_pc_nxt;
  logic             w_flush_nxt;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];

  // Only the index bits of the fetch PC matter for the lookup
  assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // Read happens before the clock-edge write, so a same-index update is not visible this cycle
  assign if_pred_taken = r_table[w_if_idx][1];

  // Squashed instructions in FLUSH never count as resolves
  assign w_resolve    = ex_valid & (ex_is_branch | ex_is_jump) & (r_state == S_IDLE);
  // A jump (even if flagged as branch too) is always taken
  assign w_actual     = ex_is_jump ? 1'b1 : br_taken;
  assign w_mispredict = w_actual != ex_pred_taken;
  assign w_correct_pc = w_actual ? ex_target : (ex_pc + 32'd4);

  assign w_ex_ctr = r_table[w_ex_idx];

  // Saturating counter step for the resolving branch's table entry
  always_comb begin
    w_ex_ctr_nxt = w_ex_ctr;
    if (w_actual) begin
      if (w_ex_ctr != 2'b11) w_ex_ctr_nxt = w_ex_ctr + 2'b01;
    end else begin
      if (w_ex_ctr != 2'b00) w_ex_ctr_nxt = w_ex_ctr - 2'b01;
    end
  end

  // Table write: conditional branches only; jumps leave the predictor alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= 2'b01;
      end
    end else if (w_resolve && ex_is_branch) begin
      r_table[w_ex_idx] <= w_ex_ctr_nxt;
    end
  end

  // FSM next-state and registered-output logic
  always_comb begin
    w_state_nxt          = r_state;
    w_down_nxt           = r_down;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_flush_nxt          = r_flush;
    case (r_state)
      S_IDLE: begin
        w_flush_nxt = 1'b0;
        if (w_resolve && w_mispredict) begin
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = w_correct_pc;
          w_flush_nxt          = 1'b1;
          w_down_nxt           = FLUSH_INIT;
          w_state_nxt          = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_flush_nxt = 1'b1;
        if (r_down == 3'd0) begin
          w_flush_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_down_nxt = r_down - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_flush_nxt = 1'b0;
        w_down_nxt  = 3'd0;
      end
    endcase
  end

  // FSM state and redirect/flush output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_down           <= 3'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush          <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_down           <= w_down_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_flush          <= w_flush_nxt;
    end
  end

  // Saturating performance counters, stepped only on accepted resolves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_resolve) begin
      if (ex_is_branch && (r_branch_cnt != {CNT_W{1'b1}})) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mispredict && (r_mispredict_cnt != {CNT_W{1'b1}})) begin
        r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      end
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Every expected value below is hand-derived from the predictor/FSM rules.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        br_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.IDX_W(6), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .br_taken       (br_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jmp, input logic pred, input logic taken,
                       input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid      = 1'b1;
    ex_is_branch  = br;
    ex_is_jump    = jmp;
    ex_pred_taken = pred;
    br_taken      = taken;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jump   = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(tag, 32'(if_pred_taken), 32'(exp));
  endtask

  task automatic check_out(input string tag, input logic rv, input logic fl);
    check({tag, "_rv"}, 32'(redirect_valid), 32'(rv));
    check({tag, "_fl"}, 32'(flush), 32'(fl));
  endtask

  task automatic check_cnt(input string tag, input int br, input int mp);
    check({tag, "_bcnt"}, branch_cnt, 32'(br));
    check({tag, "_mcnt"}, mispredict_cnt, 32'(mp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_pc = 32'd0;
    ex_pc = 32'd0;
    ex_target = 32'd0;
    ex_pred_taken = 1'b0;
    br_taken = 1'b0;
    idle_ex();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    lookup("rst_pred", 32'h100, 1'b0);
    check_out("rst", 1'b0, 1'b0);
    check("rst_rpc", redirect_pc, 32'h0);
    check_cnt("rst", 0, 0);

    // Taken branch predicted not-taken at idx 0: redirect + 2-cycle flush
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80);
    lookup("rbw_pred", 32'h100, 1'b0);   // pre-update value during write cycle
    tick();
    idle_ex();
    check_out("mp1_c1", 1'b1, 1'b1);
    check("mp1_rpc", redirect_pc, 32'h80);
    tick();
    check_out("mp1_c2", 1'b0, 1'b1);
    tick();
    check_out("mp1_c3", 1'b0, 1'b0);
    check("mp1_rpc_hold", redirect_pc, 32'h80);
    check_cnt("mp1", 1, 1);
    lookup("mp1_pred", 32'h100, 1'b1);   // counter 01 -> 10

    // Saturation at idx 1: 1->2 (mispredict), 2->3, 3->3, 3->2, 2->1
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h84);
    tick();
    idle_ex();
    check_out("sat_r1", 1'b1, 1'b1);
    check("sat_rpc", redirect_pc, 32'h84);
    tick();
    tick();
    check_out("sat_idle", 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h84);
    tick();
    check_out("sat_r2", 1'b0, 1'b0);
    lookup("sat_r2_pred", 32'h104, 1'b1);
    tick();
    check_out("sat_r3", 1'b0, 1'b0);
    lookup("sat_r3_pred", 32'h104, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h84);
    tick();
    idle_ex();
    check_out("sat_r4", 1'b0, 1'b0);
    lookup("sat_r4_pred", 32'h104, 1'b1);
    check_cnt("sat", 5, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h84);
    tick();
    idle_ex();
    lookup("sat_r5_pred", 32'h104, 1'b0);
    check_cnt("sat5", 6, 2);

    // Fall-through wrap: 0xFFFFFFFC + 4 = 0
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234);
    tick();
    idle_ex();
    check_out("wrap", 1'b1, 1'b1);
    check("wrap_rpc", redirect_pc, 32'h0);
    tick();
    tick();
    check_cnt("wrap", 7, 3);
    lookup("wrap_pred", 32'hFFFF_FFFC, 1'b0);

    // jal predicted not-taken; a resolve during FLUSH is ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h400);
    tick();
    check_out("jal", 1'b1, 1'b1);
    check("jal_rpc", redirect_pc, 32'h400);
    check_cnt("jal", 7, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 32'h999);
    tick();
    check_out("ign_c2", 1'b0, 1'b1);
    tick();
    idle_ex();
    check_out("ign_c3", 1'b0, 1'b0);
    check_cnt("ign", 7, 4);
    lookup("jal_tbl", 32'h108, 1'b0);
    tick();
    check_out("ign_late", 1'b0, 1'b0);
    check("ign_rpc", redirect_pc, 32'h400);

    // Branch and jump both set: jump redirect, table still updated
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h110, 32'h500);
    tick();
    idle_ex();
    check_out("both", 1'b1, 1'b1);
    check("both_rpc", redirect_pc, 32'h500);
    check_cnt("both", 8, 5);
    lookup("both_pred", 32'h110, 1'b1);
    tick();
    tick();

    // Asynchronous reset during the second flush cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h40);
    tick();
    idle_ex();
    check_out("rmid_c1", 1'b1, 1'b1);
    tick();
    check_out("rmid_c2", 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_out("rmid", 1'b0, 1'b0);
    check("rmid_rpc", redirect_pc, 32'h0);
    check_cnt("rmid", 0, 0);
    lookup("rmid_tbl0", 32'h100, 1'b0);
    lookup("rmid_tbl4", 32'h110, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_out("post_rst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
